death_respawn_ctrl: RTL and testbench

- Sequences the player's death/respawn cycle on top of the lives counter.
- Turns a raw hazard collision into a single life-decrement pulse, then runs a frozen death animation.
- Then either requests a respawn followed by a timed invulnerability window, or latches game-over when no lives remain.
- Sits between the collision detector / frame timing and the lives FSM, the player movement logic and the sprite drawer.

---
 rtl/game_pkg.sv | 17 +
 rtl/frame_down_counter.sv | 28 ++
 rtl/death_respawn_ctrl.sv | 127 ++++++++++++
 tb/tb_death_respawn_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default frame constants for the player death/respawn logic.
package game_pkg;

   typedef enum logic [2:0] {
      ALIVE     = 3'd0,
      DYING     = 3'd1,
      RESPAWN   = 3'd2,
      INVULN    = 3'd3,
      GAME_OVER = 3'd4
   } death_state_t;

   localparam int DEATH_FRAMES_D  = 60;
   localparam int INVULN_FRAMES_D = 120;
   localparam int BLINK_PERIOD_D  = 8;
   localparam int MAX_LIVES       = 3;

endpackage

// File: rtl/frame_down_counter.sv
// Frame-paced down-counter: loads a value, counts down on each tick and
// flags expiry on the tick that finds it at 1 (it never decrements past 1).
module frame_down_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_reg;

   // Load has priority over counting; the value 1 is held so the owner sees expiry instead.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         cnt_reg <= '0;
      else if (load)
         cnt_reg <= load_val;
      else if (tick && (cnt_reg > CNT_W'(1)))
         cnt_reg <= cnt_reg - CNT_W'(1);
   end

   assign expire = tick && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/death_respawn_ctrl.sv
// Player death/respawn sequencer: one life-decrement per hit, frozen death
// animation, then respawn with blinking invulnerability or sticky game-over.
module death_respawn_ctrl
   import game_pkg::*;
#(
   parameter int DEATH_FRAMES  = DEATH_FRAMES_D,
   parameter int INVULN_FRAMES = INVULN_FRAMES_D,
   parameter int BLINK_PERIOD  = BLINK_PERIOD_D,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       hitHazard,
   input  logic       cheatImmortal,
   input  logic [3:0] remainingLives,
   output logic       decreaseLife,
   output logic       immortal,
   output logic       playerFreeze,
   output logic       deathAnim,
   output logic       respawnReq,
   output logic       blink,
   output logic       gameOver
);

   death_state_t     state_reg, state_next;
   logic             dl_reg, dl_next;
   logic             blink_reg, blink_next;
   logic             imm_reg;
   logic             main_load, blink_load;
   logic [CNT_W-1:0] main_val;
   logic             main_tick, blink_tick;
   logic             main_exp, blink_exp;

   // Main counter paces both the death animation and the invulnerability window.
   assign main_tick  = startOfFrame && ((state_reg == DYING) || (state_reg == INVULN));
   assign blink_tick = startOfFrame && (state_reg == INVULN);

   frame_down_counter #(.CNT_W(CNT_W)) u_main_cnt (
      .clk      (clk),
      .resetN   (resetN),
      .load     (main_load),
      .load_val (main_val),
      .tick     (main_tick),
      .expire   (main_exp)
   );

   frame_down_counter #(.CNT_W(CNT_W)) u_blink_cnt (
      .clk      (clk),
      .resetN   (resetN),
      .load     (blink_load),
      .load_val (CNT_W'(BLINK_PERIOD)),
      .tick     (blink_tick),
      .expire   (blink_exp)
   );

   // State, decrement pulse, blink strobe and immortality flag registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg <= ALIVE;
         dl_reg    <= 1'b0;
         blink_reg <= 1'b0;
         imm_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         dl_reg    <= dl_next;
         blink_reg <= blink_next;
         imm_reg   <= cheatImmortal || (state_next != ALIVE);
      end
   end

   // Next-state and counter control; a hit in ALIVE outranks a same-clk frame tick.
   always_comb begin
      state_next = state_reg;
      dl_next    = 1'b0;
      blink_next = blink_reg;
      main_load  = 1'b0;
      main_val   = CNT_W'(DEATH_FRAMES);
      blink_load = 1'b0;
      case (state_reg)
         ALIVE: begin
            if (hitHazard && !cheatImmortal) begin
               state_next = DYING;
               main_load  = 1'b1;
               main_val   = CNT_W'(DEATH_FRAMES);
               dl_next    = 1'b1;
            end
         end
         DYING: begin
            if (main_exp)
               state_next = (remainingLives == 4'd0) ? GAME_OVER : RESPAWN;
         end
         RESPAWN: begin
            state_next = INVULN;
            main_load  = 1'b1;
            main_val   = CNT_W'(INVULN_FRAMES);
            blink_load = 1'b1;
            blink_next = 1'b0;
         end
         INVULN: begin
            if (main_exp) begin
               state_next = ALIVE;
               blink_next = 1'b0;
            end else if (blink_exp) begin
               blink_next = ~blink_reg;
               blink_load = 1'b1;
            end
         end
         GAME_OVER: begin
            state_next = GAME_OVER;
         end
         default: begin
            state_next = ALIVE;
            blink_next = 1'b0;
         end
      endcase
   end

   assign decreaseLife = dl_reg;
   assign immortal     = imm_reg;
   assign playerFreeze = (state_reg == DYING) || (state_reg == RESPAWN) || (state_reg == GAME_OVER);
   assign deathAnim    = (state_reg == DYING);
   assign respawnReq   = (state_reg == RESPAWN);
   assign blink        = blink_reg;
   assign gameOver     = (state_reg == GAME_OVER);

endmodule

// File: tb/tb_death_respawn_ctrl.sv
// Directed bench for death_respawn_ctrl. Output vector order:
// {decreaseLife, immortal, playerFreeze, deathAnim, respawnReq, blink, gameOver}
module tb_death_respawn_ctrl;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       hitHazard = 1'b0;
   logic       cheatImmortal = 1'b0;
   logic [3:0] remainingLives = 4'd3;

   logic dl_a, imm_a, frz_a, anim_a, rsp_a, blk_a, go_a;
   logic dl_b, imm_b, frz_b, anim_b, rsp_b, blk_b, go_b;
   logic [6:0] outs_a, outs_b;

   int vectors = 0;
   int errors  = 0;
   int dl_cnt  = 0;
   int rsp_cnt = 0;
   int base_dl, base_rsp;

   always #5 clk = ~clk;

   death_respawn_ctrl #(.DEATH_FRAMES(3), .INVULN_FRAMES(4), .BLINK_PERIOD(2), .CNT_W(8)) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .hitHazard(hitHazard),
      .cheatImmortal(cheatImmortal), .remainingLives(remainingLives),
      .decreaseLife(dl_a), .immortal(imm_a), .playerFreeze(frz_a), .deathAnim(anim_a),
      .respawnReq(rsp_a), .blink(blk_a), .gameOver(go_a));

   death_respawn_ctrl #(.DEATH_FRAMES(1), .INVULN_FRAMES(4), .BLINK_PERIOD(2), .CNT_W(8)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .hitHazard(hitHazard),
      .cheatImmortal(cheatImmortal), .remainingLives(remainingLives),
      .decreaseLife(dl_b), .immortal(imm_b), .playerFreeze(frz_b), .deathAnim(anim_b),
      .respawnReq(rsp_b), .blink(blk_b), .gameOver(go_b));

   assign outs_a = {dl_a, imm_a, frz_a, anim_a, rsp_a, blk_a, go_a};
   assign outs_b = {dl_b, imm_b, frz_b, anim_b, rsp_b, blk_b, go_b};

   // Pulse counters for dut_a, sampled mid-cycle.
   always @(negedge clk) begin
      if (dl_a)  dl_cnt++;
      if (rsp_a) rsp_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic do_reset();
      hitHazard = 1'b0; startOfFrame = 1'b0; cheatImmortal = 1'b0; remainingLives = 4'd3;
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL reset_a got %b want %b", outs_a, 7'b0000000); end
      vectors++; if (outs_b !== 7'b0000000) begin errors++; $display("FAIL reset_b got %b want %b", outs_b, 7'b0000000); end
      $display("reset: outs_a=%b outs_b=%b", outs_a, outs_b);
   endtask

   task automatic test_normal();
      do_reset();
      hitHazard = 1'b1; step(); hitHazard = 1'b0;
      vectors++; if (outs_a !== 7'b1111000) begin errors++; $display("FAIL normal_hit got %b want %b", outs_a, 7'b1111000); end
      remainingLives = 4'd2;
      step();
      vectors++; if (outs_a !== 7'b0111000) begin errors++; $display("FAIL normal_dying got %b want %b", outs_a, 7'b0111000); end
      frame(); frame();
      vectors++; if (outs_a !== 7'b0111000) begin errors++; $display("FAIL normal_dying_f2 got %b want %b", outs_a, 7'b0111000); end
      frame();
      vectors++; if (outs_a !== 7'b0110100) begin errors++; $display("FAIL normal_respawn got %b want %b", outs_a, 7'b0110100); end
      step();
      vectors++; if (outs_a !== 7'b0100000) begin errors++; $display("FAIL normal_invuln got %b want %b", outs_a, 7'b0100000); end
      frame();
      vectors++; if (outs_a !== 7'b0100000) begin errors++; $display("FAIL normal_inv_f1 got %b want %b", outs_a, 7'b0100000); end
      frame();
      vectors++; if (outs_a !== 7'b0100010) begin errors++; $display("FAIL normal_inv_f2 got %b want %b", outs_a, 7'b0100010); end
      frame();
      vectors++; if (outs_a !== 7'b0100010) begin errors++; $display("FAIL normal_inv_f3 got %b want %b", outs_a, 7'b0100010); end
      frame();
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL normal_alive got %b want %b", outs_a, 7'b0000000); end
      $display("normal: sequence done, outs_a=%b", outs_a);
   endtask

   task automatic test_hold_hit();
      do_reset();
      base_dl = dl_cnt;
      hitHazard = 1'b1; remainingLives = 4'd2;
      step();
      vectors++; if (outs_a !== 7'b1111000) begin errors++; $display("FAIL hold_hit got %b want %b", outs_a, 7'b1111000); end
      frame(); frame(); frame(); step();
      frame(); frame(); frame(); frame();
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL hold_alive got %b want %b", outs_a, 7'b0000000); end
      vectors++; if ((dl_cnt - base_dl) !== 1) begin errors++; $display("FAIL hold_pulses got %0d want %0d", dl_cnt - base_dl, 1); end
      step();
      vectors++; if (outs_a !== 7'b1111000) begin errors++; $display("FAIL hold_rehit got %b want %b", outs_a, 7'b1111000); end
      hitHazard = 1'b0;
      $display("hold: decrements in first death=%0d", 1);
   endtask

   task automatic test_game_over();
      do_reset();
      base_rsp = rsp_cnt;
      hitHazard = 1'b1; step(); hitHazard = 1'b0;
      remainingLives = 4'd0;
      step();
      frame(); frame(); frame();
      vectors++; if (outs_a !== 7'b0110001) begin errors++; $display("FAIL go_enter got %b want %b", outs_a, 7'b0110001); end
      hitHazard = 1'b1; cheatImmortal = 1'b1;
      frame(); frame(); frame(); frame(); frame();
      hitHazard = 1'b0; cheatImmortal = 1'b0;
      step(); step();
      vectors++; if (outs_a !== 7'b0110001) begin errors++; $display("FAIL go_sticky got %b want %b", outs_a, 7'b0110001); end
      vectors++; if (rsp_cnt !== base_rsp) begin errors++; $display("FAIL go_no_respawn got %0d want %0d", rsp_cnt - base_rsp, 0); end
      resetN = 1'b0; #1;
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL go_reset got %b want %b", outs_a, 7'b0000000); end
      resetN = 1'b1; remainingLives = 4'd3;
      step();
      $display("game_over: sticky until reset, outs_a=%b", outs_a);
   endtask

   task automatic test_cheat();
      do_reset();
      base_dl = dl_cnt;
      cheatImmortal = 1'b1;
      step();
      vectors++; if (outs_a !== 7'b0100000) begin errors++; $display("FAIL cheat_imm got %b want %b", outs_a, 7'b0100000); end
      for (int i = 0; i < 4; i++) begin
         hitHazard = 1'b1; step(); hitHazard = 1'b0; frame();
      end
      vectors++; if (outs_a !== 7'b0100000) begin errors++; $display("FAIL cheat_alive got %b want %b", outs_a, 7'b0100000); end
      vectors++; if (dl_cnt !== base_dl) begin errors++; $display("FAIL cheat_no_dec got %0d want %0d", dl_cnt - base_dl, 0); end
      cheatImmortal = 1'b0;
      $display("cheat: hits ignored, outs_a=%b", outs_a);
   endtask

   task automatic test_same_clk();
      do_reset();
      hitHazard = 1'b1; startOfFrame = 1'b1; step(); hitHazard = 1'b0; startOfFrame = 1'b0;
      vectors++; if (outs_a !== 7'b1111000) begin errors++; $display("FAIL same_hit got %b want %b", outs_a, 7'b1111000); end
      frame(); frame();
      vectors++; if (outs_a !== 7'b0111000) begin errors++; $display("FAIL same_full_count got %b want %b", outs_a, 7'b0111000); end
      frame();
      vectors++; if (outs_a !== 7'b0110100) begin errors++; $display("FAIL same_respawn got %b want %b", outs_a, 7'b0110100); end
      $display("same_clk: full count kept, outs_a=%b", outs_a);
   endtask

   task automatic test_one_frame();
      do_reset();
      hitHazard = 1'b1; step(); hitHazard = 1'b0;
      vectors++; if (outs_b !== 7'b1111000) begin errors++; $display("FAIL one_hit got %b want %b", outs_b, 7'b1111000); end
      step();
      frame();
      vectors++; if (outs_b !== 7'b0110100) begin errors++; $display("FAIL one_expire got %b want %b", outs_b, 7'b0110100); end
      $display("one_frame: outs_b=%b", outs_b);
   endtask

   task automatic test_reset_mid();
      do_reset();
      hitHazard = 1'b1; step(); hitHazard = 1'b0; step();
      resetN = 1'b0; #1;
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL rst_dying got %b want %b", outs_a, 7'b0000000); end
      resetN = 1'b1; step();
      hitHazard = 1'b1; step(); hitHazard = 1'b0;
      vectors++; if (outs_a !== 7'b1111000) begin errors++; $display("FAIL rst_rehit got %b want %b", outs_a, 7'b1111000); end
      frame(); frame(); frame(); step();
      frame(); frame();
      vectors++; if (outs_a !== 7'b0100010) begin errors++; $display("FAIL rst_inv_blink got %b want %b", outs_a, 7'b0100010); end
      resetN = 1'b0; #1;
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL rst_invuln got %b want %b", outs_a, 7'b0000000); end
      resetN = 1'b1; step(); step();
      vectors++; if (outs_a !== 7'b0000000) begin errors++; $display("FAIL rst_no_pending got %b want %b", outs_a, 7'b0000000); end
      hitHazard = 1'b1; step(); hitHazard = 1'b0;
      vectors++; if (outs_a !== 7'b1111000) begin errors++; $display("FAIL rst_after got %b want %b", outs_a, 7'b1111000); end
      $display("reset_mid: outs_a=%b", outs_a);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_hold_hit();
      test_game_over();
      test_cheat();
      test_same_clk();
      test_one_frame();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
